// File: rtl/mem_arbiter.sv
// Shares one single-port synchronous RAM between the CPU, the GPU and video scanout.
// Writes are posted through one-entry buffers; reads get one ack pulse one cycle after their grant.
module mem_arbiter #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cpu_mem_read,
  input  logic [ADDR_W-1:0] cpu_mem_read_idx,
  output logic              cpu_mem_read_ack,
  input  logic              cpu_mem_write,
  input  logic [ADDR_W-1:0] cpu_mem_write_idx,
  input  logic [DATA_W-1:0] cpu_mem_write_byte,
  input  logic              gpu_mem_read,
  input  logic [ADDR_W-1:0] gpu_mem_read_idx,
  output logic              gpu_mem_read_ack,
  input  logic              gpu_mem_write,
  input  logic [ADDR_W-1:0] gpu_mem_write_idx,
  input  logic [DATA_W-1:0] gpu_mem_write_byte,
  input  logic              vid_mem_read,
  input  logic [ADDR_W-1:0] vid_mem_read_idx,
  output logic              vid_mem_read_ack,
  output logic [DATA_W-1:0] rd_byte,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_we,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic              wr_overflow
);

  typedef enum logic [2:0] {
    G_NONE   = 3'd0,
    G_VID    = 3'd1,
    G_GPU_WR = 3'd2,
    G_CPU_WR = 3'd3,
    G_CPU_RD = 3'd4,
    G_GPU_RD = 3'd5
  } grant_e;

  logic              cpu_wb_valid, gpu_wb_valid;
  logic [ADDR_W-1:0] cpu_wb_idx, gpu_wb_idx;
  logic [DATA_W-1:0] cpu_wb_byte, gpu_wb_byte;
  logic              cpu_ack_q, gpu_ack_q, vid_ack_q;
  logic              rr_gpu;
  logic              overflow_q;
  logic [ADDR_W-1:0] addr_q;

  logic   cpu_rd_ok, gpu_rd_ok, vid_rd_ok;
  grant_e grant;

  // A port that is owed an ack this cycle, or still has a posted write, may not read.
  always_comb begin
    cpu_rd_ok = cpu_mem_read && !cpu_ack_q && !cpu_wb_valid;
    gpu_rd_ok = gpu_mem_read && !gpu_ack_q && !gpu_wb_valid;
    vid_rd_ok = vid_mem_read && !vid_ack_q;
    grant     = G_NONE;
    if (vid_rd_ok)                        grant = G_VID;
    else if (gpu_wb_valid)                grant = G_GPU_WR;
    else if (cpu_wb_valid)                grant = G_CPU_WR;
    else if (cpu_rd_ok && (!gpu_rd_ok || !rr_gpu)) grant = G_CPU_RD;
    else if (gpu_rd_ok)                   grant = G_GPU_RD;
  end

  always_comb begin
    ram_we    = 1'b0;
    ram_addr  = addr_q;
    ram_wdata = cpu_wb_byte;
    unique case (grant)
      G_VID:    ram_addr = vid_mem_read_idx;
      G_GPU_WR: begin
        ram_we    = 1'b1;
        ram_addr  = gpu_wb_idx;
        ram_wdata = gpu_wb_byte;
      end
      G_CPU_WR: begin
        ram_we    = 1'b1;
        ram_addr  = cpu_wb_idx;
      end
      G_CPU_RD: ram_addr = cpu_mem_read_idx;
      G_GPU_RD: ram_addr = gpu_mem_read_idx;
      default:  ;
    endcase
  end

  assign cpu_mem_read_ack = cpu_ack_q;
  assign gpu_mem_read_ack = gpu_ack_q;
  assign vid_mem_read_ack = vid_ack_q;
  assign rd_byte          = ram_rdata;
  assign wr_overflow      = overflow_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cpu_wb_valid <= 1'b0;
      gpu_wb_valid <= 1'b0;
      cpu_wb_idx   <= '0;
      gpu_wb_idx   <= '0;
      cpu_wb_byte  <= '0;
      gpu_wb_byte  <= '0;
      cpu_ack_q    <= 1'b0;
      gpu_ack_q    <= 1'b0;
      vid_ack_q    <= 1'b0;
      rr_gpu       <= 1'b0;
      overflow_q   <= 1'b0;
      addr_q       <= '0;
    end else begin
      cpu_ack_q <= (grant == G_CPU_RD);
      gpu_ack_q <= (grant == G_GPU_RD);
      vid_ack_q <= (grant == G_VID);
      addr_q    <= ram_addr;

      // The pointer moves to the port that did not just get a read.
      if (grant == G_CPU_RD) rr_gpu <= 1'b1;
      if (grant == G_GPU_RD) rr_gpu <= 1'b0;

      if (grant == G_GPU_WR) gpu_wb_valid <= 1'b0;
      if (gpu_mem_write) begin
        if (!gpu_wb_valid || grant == G_GPU_WR) begin
          gpu_wb_valid <= 1'b1;
          gpu_wb_idx   <= gpu_mem_write_idx;
          gpu_wb_byte  <= gpu_mem_write_byte;
        end else begin
          overflow_q <= 1'b1;
        end
      end

      if (grant == G_CPU_WR) cpu_wb_valid <= 1'b0;
      if (cpu_mem_write) begin
        if (!cpu_wb_valid || grant == G_CPU_WR) begin
          cpu_wb_valid <= 1'b1;
          cpu_wb_idx   <= cpu_mem_write_idx;
          cpu_wb_byte  <= cpu_mem_write_byte;
        end else begin
          overflow_q <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: behavioural sync RAM plus hand-computed expectations.
// Unwritten RAM bytes read as addr[7:0] ^ 0xA5.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cpu_mem_read = 1'b0;
  logic [11:0] cpu_mem_read_idx = '0;
  logic        cpu_mem_read_ack;
  logic        cpu_mem_write = 1'b0;
  logic [11:0] cpu_mem_write_idx = '0;
  logic [7:0]  cpu_mem_write_byte = '0;
  logic        gpu_mem_read = 1'b0;
  logic [11:0] gpu_mem_read_idx = '0;
  logic        gpu_mem_read_ack;
  logic        gpu_mem_write = 1'b0;
  logic [11:0] gpu_mem_write_idx = '0;
  logic [7:0]  gpu_mem_write_byte = '0;
  logic        vid_mem_read = 1'b0;
  logic [11:0] vid_mem_read_idx = '0;
  logic        vid_mem_read_ack;
  logic [7:0]  rd_byte;
  logic [11:0] ram_addr;
  logic        ram_we;
  logic [7:0]  ram_wdata;
  logic [7:0]  ram_rdata;
  logic        wr_overflow;

  int n_checks = 0;
  int n_fail   = 0;

  // clock / reset block
  always #5 clk = ~clk;

  mem_arbiter #(.ADDR_W(12), .DATA_W(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .cpu_mem_read(cpu_mem_read), .cpu_mem_read_idx(cpu_mem_read_idx),
    .cpu_mem_read_ack(cpu_mem_read_ack), .cpu_mem_write(cpu_mem_write),
    .cpu_mem_write_idx(cpu_mem_write_idx), .cpu_mem_write_byte(cpu_mem_write_byte),
    .gpu_mem_read(gpu_mem_read), .gpu_mem_read_idx(gpu_mem_read_idx),
    .gpu_mem_read_ack(gpu_mem_read_ack), .gpu_mem_write(gpu_mem_write),
    .gpu_mem_write_idx(gpu_mem_write_idx), .gpu_mem_write_byte(gpu_mem_write_byte),
    .vid_mem_read(vid_mem_read), .vid_mem_read_idx(vid_mem_read_idx),
    .vid_mem_read_ack(vid_mem_read_ack), .rd_byte(rd_byte),
    .ram_addr(ram_addr), .ram_we(ram_we), .ram_wdata(ram_wdata),
    .ram_rdata(ram_rdata), .wr_overflow(wr_overflow)
  );

  // RAM model: 1-cycle registered read, old data on read-during-write
  logic [7:0] mem     [0:4095];
  logic       written [0:4095];
  logic       ram_clr = 1'b1;

  function automatic logic [7:0] peek(input logic [11:0] a);
    return written[a] ? mem[a] : (a[7:0] ^ 8'hA5);
  endfunction

  always @(posedge clk) begin
    if (ram_clr) begin
      for (int i = 0; i < 4096; i++) written[i] <= 1'b0;
      ram_rdata <= 8'h00;
    end else begin
      ram_rdata <= peek(ram_addr);
      if (ram_we) begin
        mem[ram_addr]     <= ram_wdata;
        written[ram_addr] <= 1'b1;
      end
    end
  end

  // driver tasks: drive 1 time unit after the rising edge, observe on the falling edge
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic look();
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic acks(input string tag, input logic [2:0] exp);
    chk(tag, {13'd0, vid_mem_read_ack, gpu_mem_read_ack, cpu_mem_read_ack}, {13'd0, exp});
  endtask

  initial begin
    // reset state
    next_cycle();
    next_cycle();
    ram_clr = 1'b0;
    look();
    acks("reset_acks", 3'b000);
    chk("reset_we", ram_we, 0);
    chk("reset_ovf", wr_overflow, 0);
    next_cycle();
    rst_n = 1'b1;
    look();
    chk("idle_we", ram_we, 0);

    // all three read at once: vid, cpu, gpu, cpu
    next_cycle();
    vid_mem_read = 1'b1; vid_mem_read_idx = 12'h010;
    cpu_mem_read = 1'b1; cpu_mem_read_idx = 12'h020;
    gpu_mem_read = 1'b1; gpu_mem_read_idx = 12'h030;
    look();
    chk("rr0_addr", ram_addr, 12'h010);
    chk("rr0_we", ram_we, 0);
    next_cycle();
    vid_mem_read = 1'b0;
    look();
    chk("rr1_addr", ram_addr, 12'h020);
    acks("rr1_acks", 3'b100);
    chk("rr1_rd", rd_byte, 8'hB5);
    next_cycle();
    look();
    chk("rr2_addr", ram_addr, 12'h030);
    acks("rr2_acks", 3'b001);
    chk("rr2_rd", rd_byte, 8'h85);
    next_cycle();
    look();
    chk("rr3_addr", ram_addr, 12'h020);
    acks("rr3_acks", 3'b010);
    chk("rr3_rd", rd_byte, 8'h95);
    next_cycle();
    cpu_mem_read = 1'b0; gpu_mem_read = 1'b0;
    look();
    acks("rr4_acks", 3'b001);
    chk("rr4_we", ram_we, 0);
    next_cycle();
    look();
    acks("rr5_acks", 3'b000);

    // lone gpu read of 0x100
    next_cycle();
    gpu_mem_read = 1'b1; gpu_mem_read_idx = 12'h100;
    look();
    chk("g_rd_addr", ram_addr, 12'h100);
    chk("g_rd_we", ram_we, 0);
    acks("g_rd_acks0", 3'b000);
    next_cycle();
    gpu_mem_read = 1'b0;
    look();
    acks("g_rd_acks1", 3'b010);
    chk("g_rd_byte", rd_byte, 8'hA5);
    chk("g_rd_we1", ram_we, 0);
    next_cycle();
    look();
    acks("g_rd_acks2", 3'b000);

    // gpu write then read-after-write of the same byte
    next_cycle();
    gpu_mem_write = 1'b1; gpu_mem_write_idx = 12'h108; gpu_mem_write_byte = 8'h3C;
    look();
    chk("raw_we0", ram_we, 0);
    next_cycle();
    gpu_mem_write = 1'b0;
    gpu_mem_read = 1'b1; gpu_mem_read_idx = 12'h108;
    look();
    chk("raw_we1", ram_we, 1);
    chk("raw_waddr", ram_addr, 12'h108);
    chk("raw_wdata", ram_wdata, 8'h3C);
    acks("raw_acks1", 3'b000);
    next_cycle();
    look();
    chk("raw_we2", ram_we, 0);
    chk("raw_raddr", ram_addr, 12'h108);
    next_cycle();
    gpu_mem_read = 1'b0;
    look();
    acks("raw_acks3", 3'b010);
    chk("raw_rd", rd_byte, 8'h3C);

    // simultaneous cpu and gpu writes: gpu drains first
    next_cycle();
    cpu_mem_write = 1'b1; cpu_mem_write_idx = 12'h200; cpu_mem_write_byte = 8'h11;
    gpu_mem_write = 1'b1; gpu_mem_write_idx = 12'h10F; gpu_mem_write_byte = 8'h22;
    look();
    chk("ww_we0", ram_we, 0);
    next_cycle();
    cpu_mem_write = 1'b0; gpu_mem_write = 1'b0;
    look();
    chk("ww_we1", ram_we, 1);
    chk("ww_addr1", ram_addr, 12'h10F);
    chk("ww_data1", ram_wdata, 8'h22);
    next_cycle();
    look();
    chk("ww_we2", ram_we, 1);
    chk("ww_addr2", ram_addr, 12'h200);
    chk("ww_data2", ram_wdata, 8'h11);
    next_cycle();
    look();
    chk("ww_we3", ram_we, 0);
    chk("ww_hold_addr", ram_addr, 12'h200);
    chk("ww_ovf", wr_overflow, 0);
    chk("ww_mem_200", peek(12'h200), 8'h11);
    chk("ww_mem_10f", peek(12'h10F), 8'h22);

    // vid streaming blocks the gpu buffer: second gpu write is dropped
    next_cycle();
    vid_mem_read = 1'b1; vid_mem_read_idx = 12'h050;
    look();
    chk("ov_addr0", ram_addr, 12'h050);
    next_cycle();
    gpu_mem_write = 1'b1; gpu_mem_write_idx = 12'h110; gpu_mem_write_byte = 8'h01;
    look();
    chk("ov_we1", ram_we, 0);
    next_cycle();
    gpu_mem_write_idx = 12'h111; gpu_mem_write_byte = 8'h02;
    look();
    chk("ov_addr2", ram_addr, 12'h050);
    chk("ov_we2", ram_we, 0);
    chk("ov_flag2", wr_overflow, 0);
    next_cycle();
    gpu_mem_write = 1'b0;
    look();
    chk("ov_flag3", wr_overflow, 1);
    chk("ov_we3", ram_we, 1);
    chk("ov_waddr3", ram_addr, 12'h110);
    chk("ov_wdata3", ram_wdata, 8'h01);
    next_cycle();
    vid_mem_read = 1'b0;
    look();
    chk("ov_we4", ram_we, 0);
    next_cycle();
    next_cycle();
    look();
    chk("ov_mem_110", peek(12'h110), 8'h01);
    chk("ov_mem_111", peek(12'h111), 8'hB4);
    chk("ov_sticky", wr_overflow, 1);

    // reset right after a cpu read grant discards the read and the posted gpu write
    next_cycle();
    cpu_mem_read = 1'b1; cpu_mem_read_idx = 12'h301;
    gpu_mem_write = 1'b1; gpu_mem_write_idx = 12'h120; gpu_mem_write_byte = 8'h99;
    look();
    chk("rs_addr0", ram_addr, 12'h301);
    next_cycle();
    rst_n = 1'b0;
    gpu_mem_write = 1'b0;
    look();
    acks("rs_acks1", 3'b000);
    chk("rs_we1", ram_we, 0);
    chk("rs_ovf1", wr_overflow, 0);
    next_cycle();
    look();
    acks("rs_acks2", 3'b000);
    chk("rs_we2", ram_we, 0);
    next_cycle();
    rst_n = 1'b1;
    look();
    chk("rs_addr3", ram_addr, 12'h301);
    chk("rs_we3", ram_we, 0);
    acks("rs_acks3", 3'b000);
    next_cycle();
    cpu_mem_read = 1'b0;
    look();
    acks("rs_acks4", 3'b001);
    chk("rs_rd4", rd_byte, 8'hA4);
    next_cycle();
    look();
    acks("rs_acks5", 3'b000);
    chk("rs_mem_120", peek(12'h120), 8'h85);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
